// File: rtl/rr_decode_arbiter.sv
// rr_decode_arbiter: round-robin arbiter that shares one 3-to-8 decoder select among NREQ requesters.
// Define GRANT_TIMEOUT_EN to force-release a grant after MAX_HOLD cycles and pulse o_timeout.
module rr_decode_arbiter #(
    parameter int NREQ     = 7,
    parameter int MAX_HOLD = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [NREQ-1:0] i_req,
    input  logic            i_done,
    output logic [2:0]      o_sel,
    output logic [NREQ-1:0] o_gnt,
    output logic            o_busy,
    output logic            o_timeout
);
    // state    | meaning
    // ST_IDLE  | no grant outstanding, sel=0
    // ST_OWN   | r_owner holds the decoder, sel=r_owner+1

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [2:0]      r_ptr, w_ptr_nxt;
    logic [2:0]      r_owner, w_owner_nxt;
    logic [2:0]      r_sel, w_sel_nxt;
    logic [NREQ-1:0] r_gnt, w_gnt_nxt;
    logic            r_busy, w_busy_nxt;
    logic            w_found;
    logic [2:0]      w_pick;
    logic [3:0]      w_idx;
    logic            w_owner_req;
    logic            w_limit;
    logic            w_release;
    logic            w_grant;
`ifdef GRANT_TIMEOUT_EN
    logic [7:0]      r_hold, w_hold_nxt;
    logic            r_timeout, w_timeout_nxt;
`endif

    if (NREQ < 1 || NREQ > 7) begin : g_bad_nreq
        $error("rr_decode_arbiter: NREQ must be 1..7");
    end
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
        $error("rr_decode_arbiter: MAX_HOLD must be 2..255");
    end

    // First set request at or after the pointer, wrapping modulo NREQ.
    always_comb begin
        w_found = 1'b0;
        w_pick  = 3'd0;
        w_idx   = 4'd0;
        for (int i = 0; i < NREQ; i++) begin
            w_idx = {1'b0, r_ptr} + 4'(i);
            if (w_idx >= 4'(NREQ)) begin
                w_idx = w_idx - 4'(NREQ);
            end
            if (!w_found && i_req[w_idx[2:0]]) begin
                w_found = 1'b1;
                w_pick  = w_idx[2:0];
            end
        end
    end

    assign w_owner_req = i_req[r_owner];
`ifdef GRANT_TIMEOUT_EN
    assign w_limit = (r_hold == 8'(MAX_HOLD - 1));
`else
    assign w_limit = 1'b0;
`endif
    assign w_release = i_done | ~w_owner_req | w_limit;

    // The pointer already sits past the owner, so a releasing owner that still
    // requests is only found again when nobody else is asking.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        w_sel_nxt   = r_sel;
        w_gnt_nxt   = r_gnt;
        w_busy_nxt  = r_busy;
        w_grant     = 1'b0;
`ifdef GRANT_TIMEOUT_EN
        w_hold_nxt    = r_hold;
        w_timeout_nxt = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                w_grant = w_found;
            end
            ST_OWN: begin
                if (w_release) begin
                    w_grant = w_found;
`ifdef GRANT_TIMEOUT_EN
                    w_timeout_nxt = w_limit & ~i_done & w_owner_req;
`endif
                    if (!w_found) begin
                        w_state_nxt = ST_IDLE;
                        w_sel_nxt   = 3'd0;
                        w_gnt_nxt   = '0;
                        w_busy_nxt  = 1'b0;
                    end
                end else begin
`ifdef GRANT_TIMEOUT_EN
                    w_hold_nxt = r_hold + 8'd1;
`endif
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_sel_nxt   = 3'd0;
                w_gnt_nxt   = '0;
                w_busy_nxt  = 1'b0;
            end
        endcase

        if (w_grant) begin
            w_state_nxt         = ST_OWN;
            w_owner_nxt         = w_pick;
            w_ptr_nxt           = (w_pick == 3'(NREQ - 1)) ? 3'd0 : w_pick + 3'd1;
            w_sel_nxt           = w_pick + 3'd1;
            w_gnt_nxt           = '0;
            w_gnt_nxt[w_pick]   = 1'b1;
            w_busy_nxt          = 1'b1;
`ifdef GRANT_TIMEOUT_EN
            w_hold_nxt          = 8'd0;
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= 3'd0;
            r_owner <= 3'd0;
            r_sel   <= 3'd0;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
`ifdef GRANT_TIMEOUT_EN
            r_hold    <= 8'd0;
            r_timeout <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_owner_nxt;
            r_sel   <= w_sel_nxt;
            r_gnt   <= w_gnt_nxt;
            r_busy  <= w_busy_nxt;
`ifdef GRANT_TIMEOUT_EN
            r_hold    <= w_hold_nxt;
            r_timeout <= w_timeout_nxt;
`endif
        end
    end

    assign o_sel  = r_sel;
    assign o_gnt  = r_gnt;
    assign o_busy = r_busy;
`ifdef GRANT_TIMEOUT_EN
    assign o_timeout = r_timeout;
`else
    assign o_timeout = 1'b0;
`endif

endmodule
